conv_ctrl_engine: RTL and testbench
===================================

Name: conv_ctrl_engine

Overview:
- Sequencer for the convolution accelerator. It sits directly downstream of the memory-mapped offset/status register block.
- It consumes the start pulse plus the fm_dim, weight, input-fmap and output-fmap base offsets from that block, and returns idle/done for its status register.
- It runs a 3x3, stride-1, no-padding convolution over a square input feature map held in data memory, through a single-master valid/ready memory port.

Parameters:
- DWIDTH, 32, data and address width.
- DIM_W, 8, number of low fm_dim_i bits used; fm_dim = fm_dim_i[DIM_W-1:0].

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- start_i  input  1  single-cycle start pulse.
- fm_dim_i  input  DWIDTH  input fmap side length N.
- wt_offset_i  input  DWIDTH  weight base byte address.
- ifm_offset_i  input  DWIDTH  input fmap base byte address.
- ofm_offset_i  input  DWIDTH  output fmap base byte address.
- idle_o  output  1  engine not busy.
- done_o  output  1  last job completed.
- req_valid_o  output  1  memory request valid.
- req_ready_i  input  1  memory accepts request.
- req_write_o  output  1  1 = write, 0 = read.
- req_addr_o  output  DWIDTH  byte address, word aligned.
- req_wdata_o  output  DWIDTH  write data.
- resp_valid_i  input  1  read data valid.
- resp_data_i  input  DWIDTH  read data.

Behaviour:
- Reset values: idle_o=1, done_o=0, req_valid_o=0, req_write_o=0, req_addr_o=0, req_wdata_o=0. All counters, the accumulator and the 9 weight registers reset to 0.
- Latch on accepted start: offsets and N are captured on the start_i cycle. Later input changes do not affect the running job.
- Start acceptance: start_i is accepted only in IDLE or DONE and clears done_o on the next edge. start_i in any other state is ignored.
- States:
  - IDLE.
  - WT_REQ / WT_WAIT: load 9 weights.
  - IF_REQ / IF_WAIT: 9 reads per output pixel.
  - WR: write 1 result.
  - DONE.
- Transitions:
  - IDLE/DONE -> WT_REQ on start when N>=3.
  - IDLE/DONE -> DONE on start when N<3. No memory traffic; done_o=1 the cycle after start.
  - WT_REQ -> WT_WAIT on handshake. WT_WAIT -> WT_REQ on resp, or -> IF_REQ after the 9th weight.
  - IF_REQ -> IF_WAIT on handshake. IF_WAIT -> IF_REQ on resp, or -> WR after the 9th tap.
  - WR -> IF_REQ for the next pixel on handshake, or -> DONE after the last pixel.
- idle_o: 1 in IDLE and DONE, 0 otherwise.
- done_o: 1 only in DONE; sticky until the next accepted start.
- Addresses (byte, ×4 per word):
  - Weight: wt_offset + 4*(kr*3+kc), kr/kc in 0..2, row-major.
  - Input: ifm_offset + 4*((r+kr)*N + (c+kc)).
  - Output: ofm_offset + 4*(r*(N-2)+c).
  - r and c run 0..N-3, row-major. Address arithmetic is DWIDTH-bit, wraps mod 2^DWIDTH.
- Handshake:
  - req_valid_o, req_write_o, req_addr_o and req_wdata_o stay stable until req_valid_o && req_ready_i.
  - req_valid_o deasserts the cycle after acceptance.
  - At most one read is outstanding. A response is consumed only in a *_WAIT state; resp_valid_i is ignored elsewhere.
  - Writes produce no response.
- Arithmetic:
  - Signed DWIDTH x DWIDTH multiply, truncated to DWIDTH.
  - Accumulate mod 2^DWIDTH.
  - Accumulator cleared when entering IF_REQ for tap 0.
- Per-pixel latency: at least 9*(1 request cycle + 1 response cycle) + 1 write cycle, with zero-wait memory.
- Reset mid-operation: immediate return to reset values. Outstanding responses after reset are ignored.

Optional Feature:
- Macro: CONV_RELU_EN.
- Defined: the result written in WR is max(acc,0); negative accumulators (MSB=1) are written as 0.
- Undefined: the raw accumulator is written.

Test Plan:
- Basic 3x3: N=3, weights 1 at wt=0x100, ifm 1..9 at 0x200, ofm=0x300, zero-wait memory -> exactly one write of 45 (0x2D) to 0x300; done_o=1, idle_o=1.
- Identity kernel: N=4, centre weight 1 and others 0, ifm 1..16 -> writes 6, 7, 10, 11 to ofm+0, +4, +8, +12 in that order.
- Backpressure: repeat the N=4 case with req_ready_i low for 3 cycles per request and resp_valid_i delayed 2 cycles -> identical write sequence; addr/wdata stable while not ready.
- Degenerate and busy-start: N=2 -> done_o=1 one cycle after start with no req_valid_o. start_i pulsed mid-job -> ignored; result unchanged.
- Reset mid-job: rst=0 during the IF_WAIT of pixel 2 -> all outputs at reset values. A new N=3 job then produces 45 correctly.
- ReLU: weights -1, ifm 1..9 -> writes 0xFFFFFFD3 without CONV_RELU_EN, 0x00000000 with it.

Source files
------------

// File: rtl/conv_ctrl_engine.sv
// Convolution sequencer: 3x3 stride-1 no-padding convolution over an NxN fmap through one valid/ready port.
// Build option CONV_RELU_EN clamps negative accumulator results to zero before they are written.
module conv_ctrl_engine #(
  parameter int DWIDTH = 32,
  parameter int DIM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [DWIDTH-1:0] fm_dim_i,
  input  logic [DWIDTH-1:0] wt_offset_i,
  input  logic [DWIDTH-1:0] ifm_offset_i,
  input  logic [DWIDTH-1:0] ofm_offset_i,
  output logic              idle_o,
  output logic              done_o,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic              req_write_o,
  output logic [DWIDTH-1:0] req_addr_o,
  output logic [DWIDTH-1:0] req_wdata_o,
  input  logic              resp_valid_i,
  input  logic [DWIDTH-1:0] resp_data_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_WT_REQ, S_WT_WAIT, S_IF_REQ, S_IF_WAIT, S_WR, S_DONE
  } state_t;

  state_t            r_state;
  logic [DIM_W-1:0]  r_n;
  logic [DWIDTH-1:0] r_wt_off;
  logic [DWIDTH-1:0] r_ifm_off;
  logic [DWIDTH-1:0] r_ofm_off;
  logic [1:0]        r_kr;
  logic [1:0]        r_kc;
  logic [DIM_W-1:0]  r_row;
  logic [DIM_W-1:0]  r_col;
  logic [DWIDTH-1:0] r_acc;
  logic [DWIDTH-1:0] r_wt [0:8];
  logic              r_idle;
  logic              r_done;
  logic              r_req_valid;
  logic              r_req_write;
  logic [DWIDTH-1:0] r_req_addr;
  logic [DWIDTH-1:0] r_req_wdata;

  logic [DIM_W-1:0]  w_n_in;
  logic              w_n_ok;
  logic [3:0]        w_tap;
  logic [3:0]        w_tap_nxt;
  logic              w_last_tap;
  logic [1:0]        w_kr_nxt;
  logic [1:0]        w_kc_nxt;
  logic [DIM_W-1:0]  w_last_pos;
  logic              w_last_col;
  logic              w_last_pix;
  logic [DIM_W-1:0]  w_row_nxt;
  logic [DIM_W-1:0]  w_col_nxt;
  logic [DWIDTH-1:0] w_cur_wt;
  logic [DWIDTH-1:0] w_prod;
  logic [DWIDTH-1:0] w_acc_nxt;
  logic [DWIDTH-1:0] w_wr_data;
  logic [DWIDTH-1:0] w_ofm_addr;
  logic              w_unused_dim;

  // Input-fmap word (r+kr, c+kc) in an n-wide row-major map, as a wrapping byte address.
  function automatic logic [DWIDTH-1:0] ifmAddr(
    input logic [DWIDTH-1:0] base,
    input logic [DIM_W-1:0]  n,
    input logic [DIM_W-1:0]  r,
    input logic [DIM_W-1:0]  c,
    input logic [1:0]        kr,
    input logic [1:0]        kc
  );
    logic [DWIDTH-1:0] rr;
    logic [DWIDTH-1:0] cc;
    rr = DWIDTH'(r) + DWIDTH'(kr);
    cc = DWIDTH'(c) + DWIDTH'(kc);
    return base + ((rr * DWIDTH'(n) + cc) << 2);
  endfunction

  assign w_n_in       = fm_dim_i[DIM_W-1:0];
  assign w_n_ok       = w_n_in >= DIM_W'(3);
  assign w_unused_dim = ^fm_dim_i;

  assign w_kr_nxt   = (r_kc == 2'd2) ? r_kr + 2'd1 : r_kr;
  assign w_kc_nxt   = (r_kc == 2'd2) ? 2'd0 : r_kc + 2'd1;
  assign w_tap      = {2'b00, r_kr} * 4'd3 + {2'b00, r_kc};
  assign w_tap_nxt  = {2'b00, w_kr_nxt} * 4'd3 + {2'b00, w_kc_nxt};
  assign w_last_tap = (r_kr == 2'd2) && (r_kc == 2'd2);

  assign w_last_pos = r_n - DIM_W'(3);
  assign w_last_col = r_col == w_last_pos;
  assign w_last_pix = w_last_col && (r_row == w_last_pos);
  assign w_col_nxt  = w_last_col ? '0 : r_col + DIM_W'(1);
  assign w_row_nxt  = w_last_col ? r_row + DIM_W'(1) : r_row;

  assign w_cur_wt   = r_wt[w_tap];
  assign w_prod     = DWIDTH'($signed(resp_data_i) * $signed(w_cur_wt));
  assign w_acc_nxt  = r_acc + w_prod;
  assign w_ofm_addr = r_ofm_off +
                      ((DWIDTH'(r_row) * DWIDTH'(r_n - DIM_W'(2)) + DWIDTH'(r_col)) << 2);

`ifdef CONV_RELU_EN
  assign w_wr_data = w_acc_nxt[DWIDTH-1] ? '0 : w_acc_nxt;
`else
  assign w_wr_data = w_acc_nxt;
`endif

  // Single FSM; every request field is loaded together with req_valid so it holds until accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_wt_off    <= '0;
      r_ifm_off   <= '0;
      r_ofm_off   <= '0;
      r_kr        <= '0;
      r_kc        <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_acc       <= '0;
      for (int i = 0; i < 9; i++) r_wt[i] <= '0;
      r_idle      <= 1'b1;
      r_done      <= 1'b0;
      r_req_valid <= 1'b0;
      r_req_write <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            r_n       <= w_n_in;
            r_wt_off  <= wt_offset_i;
            r_ifm_off <= ifm_offset_i;
            r_ofm_off <= ofm_offset_i;
            r_kr      <= '0;
            r_kc      <= '0;
            r_row     <= '0;
            r_col     <= '0;
            if (w_n_ok) begin
              r_state     <= S_WT_REQ;
              r_idle      <= 1'b0;
              r_done      <= 1'b0;
              r_req_valid <= 1'b1;
              r_req_write <= 1'b0;
              r_req_addr  <= wt_offset_i;
            end else begin
              r_state <= S_DONE;
              r_idle  <= 1'b1;
              r_done  <= 1'b1;
            end
          end
        end
        S_WT_REQ: begin
          if (req_ready_i) begin
            r_req_valid <= 1'b0;
            r_state     <= S_WT_WAIT;
          end
        end
        S_WT_WAIT: begin
          if (resp_valid_i) begin
            r_wt[w_tap] <= resp_data_i;
            r_req_valid <= 1'b1;
            if (w_last_tap) begin
              r_kr       <= '0;
              r_kc       <= '0;
              r_acc      <= '0;
              r_req_addr <= r_ifm_off;
              r_state    <= S_IF_REQ;
            end else begin
              r_kr       <= w_kr_nxt;
              r_kc       <= w_kc_nxt;
              r_req_addr <= r_wt_off + (DWIDTH'(w_tap_nxt) << 2);
              r_state    <= S_WT_REQ;
            end
          end
        end
        S_IF_REQ: begin
          if (req_ready_i) begin
            r_req_valid <= 1'b0;
            r_state     <= S_IF_WAIT;
          end
        end
        S_IF_WAIT: begin
          if (resp_valid_i) begin
            r_acc       <= w_acc_nxt;
            r_req_valid <= 1'b1;
            if (w_last_tap) begin
              r_req_write <= 1'b1;
              r_req_addr  <= w_ofm_addr;
              r_req_wdata <= w_wr_data;
              r_state     <= S_WR;
            end else begin
              r_kr       <= w_kr_nxt;
              r_kc       <= w_kc_nxt;
              r_req_addr <= ifmAddr(r_ifm_off, r_n, r_row, r_col, w_kr_nxt, w_kc_nxt);
              r_state    <= S_IF_REQ;
            end
          end
        end
        S_WR: begin
          if (req_ready_i) begin
            r_req_write <= 1'b0;
            if (w_last_pix) begin
              r_req_valid <= 1'b0;
              r_idle      <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_row       <= w_row_nxt;
              r_col       <= w_col_nxt;
              r_kr        <= '0;
              r_kc        <= '0;
              r_acc       <= '0;
              r_req_addr  <= ifmAddr(r_ifm_off, r_n, w_row_nxt, w_col_nxt, 2'd0, 2'd0);
              r_state     <= S_IF_REQ;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign idle_o      = r_idle;
  assign done_o      = r_done;
  assign req_valid_o = r_req_valid;
  assign req_write_o = r_req_write;
  assign req_addr_o  = r_req_addr;
  assign req_wdata_o = r_req_wdata;

endmodule

// File: tb/tb_conv_ctrl_engine.sv
// Self-checking bench for conv_ctrl_engine: memory responder with programmable stalls and a write scoreboard.
// Expected ReLU result follows CONV_RELU_EN when the bundle is built with that macro.
module tb_conv_ctrl_engine;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [31:0] fm_dim_i;
  logic [31:0] wt_offset_i;
  logic [31:0] ifm_offset_i;
  logic [31:0] ofm_offset_i;
  logic        idle_o;
  logic        done_o;
  logic        req_valid_o;
  logic        req_ready_i;
  logic        req_write_o;
  logic [31:0] req_addr_o;
  logic [31:0] req_wdata_o;
  logic        resp_valid_i;
  logic [31:0] resp_data_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:511];
  logic [63:0] sbQ [$];
  int readyDelay = 0;
  int respDelay  = 0;
  int writesSeen = 0;

  conv_ctrl_engine #(.DWIDTH(32), .DIM_W(8)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .fm_dim_i(fm_dim_i),
    .wt_offset_i(wt_offset_i), .ifm_offset_i(ifm_offset_i), .ofm_offset_i(ofm_offset_i),
    .idle_o(idle_o), .done_o(done_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_write_o(req_write_o), .req_addr_o(req_addr_o), .req_wdata_o(req_wdata_o),
    .resp_valid_i(resp_valid_i), .resp_data_i(resp_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'h1FF);
  endfunction

  // Direct 3x3 convolution over the bench memory, pushing every expected output write in order.
  task automatic pushModel(input int n, input logic [31:0] wt, input logic [31:0] ifm, input logic [31:0] ofm);
    logic [31:0] acc;
    for (int r = 0; r <= n - 3; r++)
      for (int c = 0; c <= n - 3; c++) begin
        acc = 32'd0;
        for (int kr = 0; kr < 3; kr++)
          for (int kc = 0; kc < 3; kc++)
            acc = acc + mem[widx(ifm) + (r + kr) * n + c + kc] * mem[widx(wt) + kr * 3 + kc];
`ifdef CONV_RELU_EN
        if (acc[31]) acc = 32'd0;
`endif
        sbQ.push_back({ofm + 32'(4 * (r * (n - 2) + c)), acc});
      end
  endtask

  // Memory responder: stalls ready, delays responses, checks request stability and scores writes.
  initial begin
    logic        respPending;
    int          respCnt;
    logic [31:0] respData;
    int          readyCnt;
    logic        holdValid;
    logic [65:0] holdVec;
    logic [63:0] expWr;
    respPending = 1'b0; respCnt = 0; respData = '0; readyCnt = 0; holdValid = 1'b0; holdVec = '0;
    req_ready_i = 1'b0; resp_valid_i = 1'b0; resp_data_i = '0;
    forever begin
      @(posedge clk); #1;
      req_ready_i  = 1'b0;
      resp_valid_i = 1'b0;
      if (!rst) begin
        respPending = 1'b0; readyCnt = 0; holdValid = 1'b0;
        continue;
      end
      if (respPending) begin
        if (respCnt == 0) begin
          resp_valid_i = 1'b1;
          resp_data_i  = respData;
          respPending  = 1'b0;
        end else respCnt--;
      end
      if (holdValid)
        checkOutput("req_hold", {req_valid_o, req_write_o, req_addr_o, req_wdata_o}, holdVec);
      holdValid = 1'b0;
      if (req_valid_o) begin
        if (readyCnt < readyDelay) begin
          readyCnt++;
          holdValid = 1'b1;
          holdVec   = {req_valid_o, req_write_o, req_addr_o, req_wdata_o};
        end else begin
          req_ready_i = 1'b1;
          readyCnt    = 0;
          if (req_write_o) begin
            writesSeen++;
            if (sbQ.size() == 0) checkOutput("wr_unexpected", 128'(req_addr_o), 128'(32'hFFFF_FFFF));
            else begin
              expWr = sbQ.pop_front();
              checkOutput("wr_addr", 128'(req_addr_o), 128'(expWr[63:32]));
              checkOutput("wr_data", 128'(req_wdata_o), 128'(expWr[31:0]));
            end
          end else begin
            respPending = 1'b1;
            respCnt     = respDelay;
            respData    = mem[widx(req_addr_o)];
          end
        end
      end
    end
  end

  task automatic pulseStart(input int n, input logic [31:0] wt, input logic [31:0] ifm, input logic [31:0] ofm);
    start_i = 1'b1; fm_dim_i = 32'(n);
    wt_offset_i = wt; ifm_offset_i = ifm; ofm_offset_i = ofm;
    @(posedge clk); #1;
    start_i = 1'b0; fm_dim_i = 32'd9;
    wt_offset_i = 32'h0000_0700; ifm_offset_i = 32'h0000_0704; ofm_offset_i = 32'h0000_0708;
  endtask

  task automatic applyStimulus(input string tag, input int n, input logic [31:0] wt, input logic [31:0] ifm,
                               input logic [31:0] ofm, input int rdy, input int rsp, input bit busy);
    int cyc;
    readyDelay = rdy; respDelay = rsp;
    pulseStart(n, wt, ifm, ofm);
    checkOutput({tag, "_done_clr"}, 128'(done_o), 128'(0));
    checkOutput({tag, "_busy"}, 128'(idle_o), 128'(0));
    cyc = 0;
    while (!done_o && cyc < 5000) begin
      start_i = busy && (cyc == 30);
      @(posedge clk); #1;
      cyc++;
    end
    start_i = 1'b0;
    checkOutput({tag, "_done"}, 128'(done_o), 128'(1));
    checkOutput({tag, "_idle"}, 128'(idle_o), 128'(1));
    checkOutput({tag, "_sb_left"}, 128'(sbQ.size()), 128'(0));
    sbQ.delete();
  endtask

  initial begin
    int cyc;
    rst = 1'b0; start_i = 1'b0; fm_dim_i = '0;
    wt_offset_i = '0; ifm_offset_i = '0; ofm_offset_i = '0;
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    for (int i = 0; i < 9; i++) begin
      mem[widx(32'h100) + i] = 32'd1;
      mem[widx(32'h140) + i] = (i == 4) ? 32'd1 : 32'd0;
      mem[widx(32'h180) + i] = 32'hFFFF_FFFF;
      mem[widx(32'h1C0) + i] = 32'($urandom_range(0, 14)) - 32'd7;
    end
    for (int i = 0; i < 16; i++) mem[widx(32'h200) + i] = 32'(i + 1);
    for (int i = 0; i < 25; i++) mem[widx(32'h400) + i] = 32'($urandom_range(0, 200)) - 32'd100;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_outputs", {idle_o, done_o, req_valid_o, req_write_o, req_addr_o, req_wdata_o},
                {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0});
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] basic 3x3");
    sbQ.push_back({32'h300, 32'd45});
    applyStimulus("basic", 3, 32'h100, 32'h200, 32'h300, 0, 0, 1'b0);

    $display("[TB] identity kernel N=4");
    sbQ.push_back({32'h300, 32'd6});  sbQ.push_back({32'h304, 32'd7});
    sbQ.push_back({32'h308, 32'd10}); sbQ.push_back({32'h30C, 32'd11});
    applyStimulus("ident", 4, 32'h140, 32'h200, 32'h300, 0, 0, 1'b0);

    $display("[TB] identity kernel with backpressure");
    sbQ.push_back({32'h300, 32'd6});  sbQ.push_back({32'h304, 32'd7});
    sbQ.push_back({32'h308, 32'd10}); sbQ.push_back({32'h30C, 32'd11});
    applyStimulus("bp", 4, 32'h140, 32'h200, 32'h300, 3, 2, 1'b0);

    $display("[TB] degenerate N=2");
    readyDelay = 0; respDelay = 0;
    pulseStart(2, 32'h100, 32'h200, 32'h300);
    checkOutput("deg_done", 128'(done_o), 128'(1));
    checkOutput("deg_idle", 128'(idle_o), 128'(1));
    for (int i = 0; i < 4; i++) begin
      checkOutput("deg_no_req", 128'(req_valid_o), 128'(0));
      @(posedge clk); #1;
    end

    $display("[TB] start pulsed mid-job");
    sbQ.push_back({32'h300, 32'd6});  sbQ.push_back({32'h304, 32'd7});
    sbQ.push_back({32'h308, 32'd10}); sbQ.push_back({32'h30C, 32'd11});
    applyStimulus("busy_start", 4, 32'h140, 32'h200, 32'h300, 0, 0, 1'b1);

    $display("[TB] reset mid-job");
    sbQ.push_back({32'h300, 32'd6});  sbQ.push_back({32'h304, 32'd7});
    cyc = writesSeen;
    pulseStart(4, 32'h140, 32'h200, 32'h300);
    begin
      int guard;
      guard = 0;
      while (!(writesSeen >= cyc + 2 && !req_valid_o && !idle_o) && guard < 2000) begin
        @(posedge clk); #1;
        guard++;
      end
      checkOutput("rst_reach_if_wait", 128'(guard < 2000), 128'(1));
    end
    @(negedge clk) rst = 1'b0;
    #1;
    checkOutput("midrst_outputs", {idle_o, done_o, req_valid_o, req_write_o, req_addr_o, req_wdata_o},
                {1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0});
    checkOutput("midrst_sb_left", 128'(sbQ.size()), 128'(0));
    sbQ.delete();
    @(posedge clk); @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    sbQ.push_back({32'h300, 32'd45});
    applyStimulus("after_rst", 3, 32'h100, 32'h200, 32'h300, 0, 0, 1'b0);

    $display("[TB] negative result");
`ifdef CONV_RELU_EN
    sbQ.push_back({32'h300, 32'h0000_0000});
`else
    sbQ.push_back({32'h300, 32'hFFFF_FFD3});
`endif
    applyStimulus("relu", 3, 32'h180, 32'h200, 32'h300, 0, 0, 1'b0);

    $display("[TB] random N=5 with mild stalls");
    pushModel(5, 32'h1C0, 32'h400, 32'h600);
    applyStimulus("rand5", 5, 32'h1C0, 32'h400, 32'h600, 1, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
